// File: rtl/intra_pkg.sv
// -----------------------------------------------------------------------------
// intra_pkg
// Shared definitions for the 4x4 luma intra mode-decision slice.
//   PIX_W        : pixel bit width
//   NUM_MODES    : number of legal intra 4x4 modes (codes 0..NUM_MODES-1)
//   intra_mode_e : intra 4x4 mode codes, NONE marks "no mode chosen"
//   state_e      : mode-decision FSM states
//   pix_lsb()    : LSB position of pixel idx (idx = 4*row+col) in a packed block
// -----------------------------------------------------------------------------
package intra_pkg;

    localparam int PIX_W     = 8;
    localparam int NUM_MODES = 9;

    typedef enum logic [3:0] {
        VERT = 4'd0,
        HORZ = 4'd1,
        DC   = 4'd2,
        DDL  = 4'd3,
        DDR  = 4'd4,
        VR   = 4'd5,
        HD   = 4'd6,
        VL   = 4'd7,
        HU   = 4'd8,
        NONE = 4'hF
    } intra_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic int pix_lsb(input int idx, input int pix_w);
        return pix_w * idx;
    endfunction

endpackage

// File: rtl/sad4x4.sv
// -----------------------------------------------------------------------------
// sad4x4
// Two-stage SAD pipeline for one 4x4 candidate per cycle.
//   S1: 16 absolute differences |orig-pred| plus mode/pred/legal sideband.
//   S2: adder-tree sum of the 16 differences plus the same sideband.
// Ports:
//   clk, reset        : clock, synchronous active-low reset (clears valid bits)
//   i_valid           : candidate enters S1 this cycle
//   i_legal, i_mode   : legality flag and mode code of the candidate
//   i_orig, i_pred    : original and predicted blocks (packed pixels)
//   o_s1_valid        : S1 holds a candidate
//   o_valid           : S2 holds a candidate (o_sad/o_mode/o_pred/o_legal valid)
// -----------------------------------------------------------------------------
module sad4x4 #(
    parameter int PIX_W = intra_pkg::PIX_W,
    parameter int SAD_W = PIX_W + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic                 i_legal,
    input  logic [3:0]           i_mode,
    input  logic [16*PIX_W-1:0]  i_orig,
    input  logic [16*PIX_W-1:0]  i_pred,
    output logic                 o_s1_valid,
    output logic                 o_valid,
    output logic                 o_legal,
    output logic [3:0]           o_mode,
    output logic [SAD_W-1:0]     o_sad,
    output logic [16*PIX_W-1:0]  o_pred
);
    import intra_pkg::*;

    logic [PIX_W-1:0]    w_absdiff [16];
    logic [SAD_W-1:0]    w_sum;

    logic [PIX_W-1:0]    r_s1_absdiff [16];
    logic                r_s1_valid;
    logic                r_s1_legal;
    logic [3:0]          r_s1_mode;
    logic [16*PIX_W-1:0] r_s1_pred;

    logic                r_s2_valid;
    logic                r_s2_legal;
    logic [3:0]          r_s2_mode;
    logic [SAD_W-1:0]    r_s2_sad;
    logic [16*PIX_W-1:0] r_s2_pred;

    // Per-pixel absolute difference; subtract the smaller from the larger to stay unsigned.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            if (i_orig[pix_lsb(i, PIX_W) +: PIX_W] >= i_pred[pix_lsb(i, PIX_W) +: PIX_W]) begin
                w_absdiff[i] = i_orig[pix_lsb(i, PIX_W) +: PIX_W] - i_pred[pix_lsb(i, PIX_W) +: PIX_W];
            end else begin
                w_absdiff[i] = i_pred[pix_lsb(i, PIX_W) +: PIX_W] - i_orig[pix_lsb(i, PIX_W) +: PIX_W];
            end
        end
    end

    // Sum of the 16 registered differences; SAD_W holds 16*max pixel without overflow.
    always_comb begin
        w_sum = {SAD_W{1'b0}};
        for (int i = 0; i < 16; i++) begin
            w_sum = w_sum + SAD_W'(r_s1_absdiff[i]);
        end
    end

    // Stage 1 and stage 2 registers; data only loads with a valid candidate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_s1_absdiff[i] <= {PIX_W{1'b0}};
            end
            r_s1_valid <= 1'b0;
            r_s1_legal <= 1'b0;
            r_s1_mode  <= 4'd0;
            r_s1_pred  <= {(16*PIX_W){1'b0}};
            r_s2_valid <= 1'b0;
            r_s2_legal <= 1'b0;
            r_s2_mode  <= 4'd0;
            r_s2_sad   <= {SAD_W{1'b0}};
            r_s2_pred  <= {(16*PIX_W){1'b0}};
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                for (int i = 0; i < 16; i++) begin
                    r_s1_absdiff[i] <= w_absdiff[i];
                end
                r_s1_legal <= i_legal;
                r_s1_mode  <= i_mode;
                r_s1_pred  <= i_pred;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_legal <= r_s1_legal;
                r_s2_mode  <= r_s1_mode;
                r_s2_sad   <= w_sum;
                r_s2_pred  <= r_s1_pred;
            end
        end
    end

    assign o_s1_valid = r_s1_valid;
    assign o_valid    = r_s2_valid;
    assign o_legal    = r_s2_legal;
    assign o_mode     = r_s2_mode;
    assign o_sad      = r_s2_sad;
    assign o_pred     = r_s2_pred;

endmodule

// File: rtl/intra4x4_mode_decision.sv
// -----------------------------------------------------------------------------
// intra4x4_mode_decision
// Scores intra 4x4 candidate predictions by SAD against the original block and
// keeps the cheapest legal one (earliest wins on ties).
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start, orig_blk     : begin a block (IDLE only), latch the original pixels
//   cand_valid/_ready   : candidate handshake, one candidate per cycle
//   cand_mode/_pred/_last : candidate mode, predicted pixels, final-candidate flag
//   busy                : FSM not idle
//   done                : one-cycle pulse, best_* final
//   best_valid/_mode/_sad/_pred : winning candidate (hold until next start)
//   bad_mode            : an out-of-range mode code was seen in this block
// -----------------------------------------------------------------------------
module intra4x4_mode_decision #(
    parameter int PIX_W     = intra_pkg::PIX_W,
    parameter int NUM_MODES = intra_pkg::NUM_MODES,
    parameter int SAD_W     = PIX_W + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [16*PIX_W-1:0]  orig_blk,
    input  logic                 cand_valid,
    output logic                 cand_ready,
    input  logic [3:0]           cand_mode,
    input  logic [16*PIX_W-1:0]  cand_pred,
    input  logic                 cand_last,
    output logic                 busy,
    output logic                 done,
    output logic                 best_valid,
    output logic [3:0]           best_mode,
    output logic [SAD_W-1:0]     best_sad,
    output logic [16*PIX_W-1:0]  best_pred,
    output logic                 bad_mode
);
    import intra_pkg::*;

    state_e              r_state;
    logic                r_cand_ready;
    logic                r_busy;
    logic                r_done;
    logic [16*PIX_W-1:0] r_orig;
    logic                r_best_valid;
    logic [3:0]          r_best_mode;
    logic [SAD_W-1:0]    r_best_sad;
    logic [16*PIX_W-1:0] r_best_pred;
    logic                r_bad_mode;

    logic                w_accept;
    logic                w_legal;
    logic                w_start_ok;
    logic                w_s1_valid;
    logic                w_s2_valid;
    logic                w_s2_legal;
    logic [3:0]          w_s2_mode;
    logic [SAD_W-1:0]    w_s2_sad;
    logic [16*PIX_W-1:0] w_s2_pred;

    // r_cand_ready is high exactly in COLLECT, so it doubles as the accept gate.
    assign w_accept   = cand_valid & r_cand_ready;
    assign w_legal    = (cand_mode < 4'(NUM_MODES));
    assign w_start_ok = (r_state == ST_IDLE) & start;

    sad4x4 #(
        .PIX_W (PIX_W),
        .SAD_W (SAD_W)
    ) u_sad4x4 (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (w_accept),
        .i_legal    (w_legal),
        .i_mode     (cand_mode),
        .i_orig     (r_orig),
        .i_pred     (cand_pred),
        .o_s1_valid (w_s1_valid),
        .o_valid    (w_s2_valid),
        .o_legal    (w_s2_legal),
        .o_mode     (w_s2_mode),
        .o_sad      (w_s2_sad),
        .o_pred     (w_s2_pred)
    );

    // Block-level FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cand_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_orig       <= {(16*PIX_W){1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_COLLECT;
                        r_cand_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_orig       <= orig_blk;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept && cand_last) begin
                        r_state      <= ST_DRAIN;
                        r_cand_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // No new input in DRAIN: once S1 is empty, S2 is consumed by
                    // the compare on this same edge, so best_* is final next cycle.
                    if (!w_s1_valid) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cand_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Running best: cleared on an accepted start, updated from the S2 output.
    always_ff @(posedge clk) begin
        if (!reset || w_start_ok) begin
            r_best_valid <= 1'b0;
            r_best_mode  <= NONE;
            r_best_sad   <= {SAD_W{1'b1}};
            r_best_pred  <= {(16*PIX_W){1'b0}};
            r_bad_mode   <= 1'b0;
        end else if (w_s2_valid) begin
            if (!w_s2_legal) begin
                r_bad_mode <= 1'b1;
            end else if (!r_best_valid || (w_s2_sad < r_best_sad)) begin
                // Strict less-than: a later equal SAD never displaces the incumbent.
                r_best_valid <= 1'b1;
                r_best_mode  <= w_s2_mode;
                r_best_sad   <= w_s2_sad;
                r_best_pred  <= w_s2_pred;
            end
        end
    end

    assign cand_ready = r_cand_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign best_valid = r_best_valid;
    assign best_mode  = r_best_mode;
    assign best_sad   = r_best_sad;
    assign best_pred  = r_best_pred;
    assign bad_mode   = r_bad_mode;

endmodule

// File: tb/tb_intra4x4_mode_decision.sv
// -----------------------------------------------------------------------------
// tb_intra4x4_mode_decision
// Directed table of blocks with hand-derived results, randomized blocks checked
// against a behavioural SAD/min model, and hand sequences for start-ignore,
// done-cycle start and reset mid-block.
// -----------------------------------------------------------------------------
module tb_intra4x4_mode_decision;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] orig_blk;
    logic         cand_valid;
    logic         cand_ready;
    logic [3:0]   cand_mode;
    logic [127:0] cand_pred;
    logic         cand_last;
    logic         busy;
    logic         done;
    logic         best_valid;
    logic [3:0]   best_mode;
    logic [11:0]  best_sad;
    logic [127:0] best_pred;
    logic         bad_mode;

    int checks = 0;
    int errors = 0;

    // Current block description used by run_block and the model.
    logic [127:0] blk_orig;
    logic [127:0] c_pred [8];
    logic [3:0]   c_mode [8];
    int           c_n;

    typedef struct {
        logic [7:0]      orig;
        int              n;
        logic [2:0][3:0] m;
        logic [2:0][7:0] p;
        logic            ev;
        logic [3:0]      em;
        logic [11:0]     es;
        logic [7:0]      ep;
        logic            eb;
    } vec_t;

    vec_t vt [6];

    intra4x4_mode_decision dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .orig_blk   (orig_blk),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_mode  (cand_mode),
        .cand_pred  (cand_pred),
        .cand_last  (cand_last),
        .busy       (busy),
        .done       (done),
        .best_valid (best_valid),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .best_pred  (best_pred),
        .bad_mode   (bad_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] bcast(input logic [7:0] v);
        return {16{v}};
    endfunction

    // Reference: SAD of every legal candidate, first strict minimum wins.
    task automatic model(output logic v, output logic [3:0] m, output logic [11:0] s,
                         output logic [127:0] p, output logic bad);
        v = 1'b0; m = 4'hF; s = 12'hFFF; p = 128'd0; bad = 1'b0;
        for (int k = 0; k < c_n; k++) begin
            int sum;
            sum = 0;
            if (c_mode[k] >= 4'd9) begin
                bad = 1'b1;
            end else begin
                for (int px = 0; px < 16; px++) begin
                    int a;
                    int b;
                    a = int'(blk_orig[8*px +: 8]);
                    b = int'(c_pred[k][8*px +: 8]);
                    sum += (a > b) ? (a - b) : (b - a);
                end
                if (!v || sum < int'(s)) begin
                    v = 1'b1; m = c_mode[k]; s = sum[11:0]; p = c_pred[k];
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, cand_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_bvalid"}, best_valid, 1'b0);
        chk({tag, "_bmode"}, best_mode, 4'hF);
        chk({tag, "_bsad"}, best_sad, 12'hFFF);
        chk({tag, "_bpred"}, best_pred, 128'd0);
        chk({tag, "_bad"}, bad_mode, 1'b0);
    endtask

    // One full block: start, candidates (optional gaps), bounded wait for done.
    task automatic run_block(input int gap_max, input bit poke_start);
        int cyc;
        orig_blk = blk_orig;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        orig_blk = ~blk_orig;   // the DUT must use its latched copy from here on
        chk("ready_collect", cand_ready, 1'b1);
        chk("busy_collect", busy, 1'b1);
        for (int k = 0; k < c_n; k++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                repeat (g) tick();
            end
            if (poke_start && k == 1) begin
                start = 1'b1;   // ignored: not IDLE
                tick();
                start = 1'b0;
            end
            cand_valid = 1'b1;
            cand_mode  = c_mode[k];
            cand_pred  = c_pred[k];
            cand_last  = (k == c_n - 1);
            tick();
        end
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            chk("ready_drain", cand_ready, 1'b0);
            tick();
            cyc++;
        end
        chk("done_latency", cyc, 2);
        chk("ready_done", cand_ready, 1'b0);
        if (poke_start) start = 1'b1;   // start in DONE cycle is ignored
        tick();
        start = 1'b0;
        chk("done_single", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic compare_model(input string tag);
        logic v, b;
        logic [3:0] m;
        logic [11:0] s;
        logic [127:0] p;
        model(v, m, s, p, b);
        chk({tag, "_valid"}, best_valid, v);
        chk({tag, "_mode"}, best_mode, m);
        chk({tag, "_sad"}, best_sad, s);
        chk({tag, "_pred"}, best_pred, p);
        chk({tag, "_bad"}, bad_mode, b);
    endtask

    task automatic set_vec(input int i, input logic [7:0] o, input int n,
                           input logic [3:0] m0, input logic [7:0] p0,
                           input logic [3:0] m1, input logic [7:0] p1,
                           input logic [3:0] m2, input logic [7:0] p2,
                           input logic ev, input logic [3:0] em, input logic [11:0] es,
                           input logic [7:0] ep, input logic eb);
        vt[i].orig = o;  vt[i].n = n;
        vt[i].m[0] = m0; vt[i].p[0] = p0;
        vt[i].m[1] = m1; vt[i].p[1] = p1;
        vt[i].m[2] = m2; vt[i].p[2] = p2;
        vt[i].ev = ev; vt[i].em = em; vt[i].es = es; vt[i].ep = ep; vt[i].eb = eb;
    endtask

    initial begin
        // Hand-derived expectations (SAD = 16 * |orig - pred| for flat blocks).
        set_vec(0, 8'd100, 1, 4'd0,  8'd90,  4'd0, 8'd0,   4'd0, 8'd0,   1'b1, 4'd0, 12'd160,  8'd90,  1'b0);
        set_vec(1, 8'd100, 3, 4'd0,  8'd80,  4'd1, 8'd95,  4'd2, 8'd110, 1'b1, 4'd1, 12'd80,   8'd95,  1'b0);
        set_vec(2, 8'd100, 2, 4'd0,  8'd98,  4'd1, 8'd102, 4'd0, 8'd0,   1'b1, 4'd0, 12'd32,   8'd98,  1'b0);
        set_vec(3, 8'd0,   2, 4'd4,  8'd255, 4'd12, 8'd0,  4'd0, 8'd0,   1'b1, 4'd4, 12'd4080, 8'd255, 1'b1);
        set_vec(4, 8'd50,  2, 4'd9,  8'd50,  4'd15, 8'd50, 4'd0, 8'd0,   1'b0, 4'hF, 12'hFFF,  8'd0,   1'b1);
        set_vec(5, 8'd50,  2, 4'd13, 8'd50,  4'd8, 8'd60,  4'd0, 8'd0,   1'b1, 4'd8, 12'd160,  8'd60,  1'b1);

        reset = 1'b0; start = 1'b0; orig_blk = 128'd0;
        cand_valid = 1'b0; cand_mode = 4'd0; cand_pred = 128'd0; cand_last = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 6; i++) begin
            blk_orig = bcast(vt[i].orig);
            c_n = vt[i].n;
            for (int k = 0; k < c_n; k++) begin
                c_mode[k] = vt[i].m[k];
                c_pred[k] = bcast(vt[i].p[k]);
            end
            run_block((i % 2 == 1) ? 2 : 0, (i == 1));
            chk($sformatf("vec%0d_valid", i), best_valid, vt[i].ev);
            chk($sformatf("vec%0d_mode", i), best_mode, vt[i].em);
            chk($sformatf("vec%0d_sad", i), best_sad, vt[i].es);
            chk($sformatf("vec%0d_pred", i), best_pred, bcast(vt[i].ep));
            chk($sformatf("vec%0d_bad", i), bad_mode, vt[i].eb);
            repeat (3) tick();
            chk($sformatf("vec%0d_hold", i), best_sad, vt[i].es);
        end

        // Randomized blocks against the model
        for (int r = 0; r < 25; r++) begin
            for (int px = 0; px < 16; px++) blk_orig[8*px +: 8] = 8'($urandom);
            c_n = $urandom_range(6, 1);
            for (int k = 0; k < c_n; k++) begin
                c_mode[k] = 4'($urandom_range(11, 0));
                if ($urandom_range(7, 0) == 0) begin
                    c_pred[k] = blk_orig;
                end else begin
                    for (int px = 0; px < 16; px++) c_pred[k][8*px +: 8] = 8'($urandom);
                end
            end
            run_block((r % 2) * 2, (c_n >= 2) && (r % 3 == 0));
            compare_model($sformatf("rnd%0d", r));
        end

        // Reset mid-block: two candidates in flight, then reset low
        blk_orig = bcast(8'd20);
        orig_blk = blk_orig;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cand_valid = 1'b1;
            cand_mode  = 4'(k);
            cand_pred  = bcast(8'(10 + k));
            cand_last  = 1'b0;
            tick();
        end
        cand_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_outputs("midrst");
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                if (done === 1'b1) seen++;
                tick();
            end
            chk("midrst_no_done", seen, 0);
        end
        check_reset_outputs("midrst_after");

        // Next block after reset runs normally
        blk_orig = bcast(8'd200);
        c_n = 3;
        c_mode[0] = 4'd3; c_pred[0] = bcast(8'd190);
        c_mode[1] = 4'd5; c_pred[1] = bcast(8'd205);
        c_mode[2] = 4'd7; c_pred[2] = bcast(8'd180);
        run_block(1, 1'b0);
        chk("post_rst_mode", best_mode, 4'd5);
        chk("post_rst_sad", best_sad, 12'd80);
        compare_model("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
